video_timing_gen: RTL
=====================

// Module: video_timing_gen
// PURPOSE
//  Raster timing generator for the DVI output path. Runs in the pixel clock domain.
//  Produces the blanking flag and the hsync/vsync control bits that feed the three TMDS
//  colour channels; hsync/vsync drive c0/c1 on the blue channel.
//  Also produces the pixel coordinates and frame/line strobes that pattern or framebuffer
//  logic uses to generate color_input.
// PARAMETERS
//  H_ACTIVE    640  visible pixels per line
//  H_FP         16  horizontal front porch, in pixels
//  H_SYNC       96  hsync width, in pixels
//  H_BP         48  horizontal back porch, in pixels
//  V_ACTIVE    480  visible lines per frame
//  V_FP         10  vertical front porch, in lines
//  V_SYNC        2  vsync width, in lines
//  V_BP         33  vertical back porch, in lines
//  SYNC_POL      0  asserted level of hsync/vsync (0 = negative sync, as for 640x480)
// PORTS
//  clk          in   1   pixel clock
//  rst          in   1   asynchronous, active-low reset
//  en           in   1   advance enable; when low, the counters and outputs hold
//  hsync        out  1   horizontal sync at SYNC_POL level while asserted
//  vsync        out  1   vertical sync at SYNC_POL level while asserted
//  blanking     out  1   1 outside the active area
//  x            out  XW  horizontal count, XW = $clog2(H_TOTAL)
//  y            out  YW  vertical count, YW = $clog2(V_TOTAL)
//  line_start   out  1   1-cycle pulse when x == 0
//  frame_start  out  1   1-cycle pulse when x == 0 and y == 0
// BEHAVIOUR
//  - Totals: H_TOTAL = sum of the four H_* parameters (800 at defaults);
//    V_TOTAL = sum of the four V_* parameters (525 at defaults).
//  - Every parameter must be >= 1. Elaboration fails ($error) otherwise.
//  - Reset (rst = 0, asynchronous): h_cnt = v_cnt = 0, both phase FSMs go to ACT.
//    Output reset values: hsync = vsync = ~SYNC_POL, blanking = 1, x = y = 0,
//    line_start = frame_start = 0.
//  - Horizontal FSM. Order within a line is active, then porches and sync:
//      ACT  -> FP   when h_cnt == H_ACTIVE - 1
//      FP   -> SYNC when h_cnt == H_ACTIVE + H_FP - 1
//      SYNC -> BP   when h_cnt == H_ACTIVE + H_FP + H_SYNC - 1
//      BP   -> ACT  when h_cnt == H_TOTAL - 1; h_cnt then wraps to 0
//  - Vertical FSM has the same four states over v_cnt, and advances only on the h wrap.
//    v_cnt wraps from V_TOTAL - 1 to 0 when the h wrap occurs on the last line.
//  - Counters and FSMs update only on clk edges where en = 1.
//    When en = 0, every register holds, pulse outputs included.
//  - Outputs are registered from the counter/FSM state: latency is 1 clock.
//    The output at edge n+1 reflects the counter value held after edge n.
//    All outputs change together, with no skew between them.
//  - hsync is asserted while the H FSM is in SYNC.
//    vsync is asserted while the V FSM is in SYNC; it switches at h_cnt == 0 of the line.
//  - blanking = (H state != ACT) | (V state != ACT).
//    x and y carry h_cnt and v_cnt in all phases; consumers qualify them with ~blanking.
//  - line_start and frame_start are high for exactly one enabled cycle.
//    With en held low, they stay high for as long as en stays low.
//  - Reset asserted mid-frame returns all state to the reset values immediately.
//    After reset release, the first enabled edge presents x = 0, y = 0,
//    line_start = frame_start = 1 and blanking = 0.
// STRUCTURE
//  - Package video_timing_pkg holds:
//    - phase_t enum {ACT, FP, SYNC, BP};
//    - the 640x480@60 constant set;
//    - a function computing a total from its four segments.
//  - Sub-module timing_axis, instantiated twice: H with step = en, V with step = en & h_wrap.
//    Parameters: ACTIVE, FP, SYNC, BP.
//    Ports: clk, rst, step, cnt, phase, wrap.
//    The top level adds the output registers and strobe decode.
// TESTING
//  1. Reset, then en = 1 for 2 frames -> each line is 800 clocks and each frame 420000 clocks;
//     frame_start pulses exactly once per frame.
//  2. Line 0 -> blanking = 0 for x = 0..639;
//     hsync = 0 for x = 656..751, and 1 at x = 655 and x = 752.
//  3. Frame scan -> vsync = 0 on y = 490..491 only; blanking = 1 for all of y = 480..524.
//  4. At x = 799, y = 524 -> the next output is x = 0, y = 0, frame_start = 1, line_start = 1.
//  5. en = 0 for 37 cycles at x = 300 -> x stays 300 and all outputs are frozen;
//     the line then resumes and still totals 800 enabled edges.
//  6. rst pulsed low asynchronously (between clk edges) at x = 700, y = 100 -> outputs take
//     their reset values before the next clk edge; the first enabled edge after release
//     gives x = 0, y = 0.
//  7. Parameter override H_ACTIVE = 4, H_FP = 1, H_SYNC = 1, H_BP = 1 with the same checks
//     -> a 7-clock line, and the hsync position matches the FSM rules.

Source files
------------

// File: rtl/video_timing_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | video_timing_pkg: phase encoding and 640x480@60 constants for the raster   |
// | timing generator.                                                          |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package video_timing_pkg;

  typedef enum logic [1:0] {
    ACT  = 2'd0,
    FP   = 2'd1,
    SYNC = 2'd2,
    BP   = 2'd3
  } phase_t;

  localparam int C_VGA_H_ACTIVE = 640;
  localparam int C_VGA_H_FP     = 16;
  localparam int C_VGA_H_SYNC   = 96;
  localparam int C_VGA_H_BP     = 48;
  localparam int C_VGA_V_ACTIVE = 480;
  localparam int C_VGA_V_FP     = 10;
  localparam int C_VGA_V_SYNC   = 2;
  localparam int C_VGA_V_BP     = 33;
  localparam bit C_VGA_SYNC_POL = 1'b0;

  function automatic int total_of(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

endpackage
`default_nettype wire

// File: rtl/timing_axis.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | timing_axis: one raster axis - position counter plus ACT/FP/SYNC/BP phase. |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module timing_axis
  import video_timing_pkg::phase_t;
  import video_timing_pkg::total_of;
#(
  parameter int ACTIVE = 640,
  parameter int FP     = 16,
  parameter int SYNC   = 96,
  parameter int BP     = 48,
  localparam int TOTAL = total_of(ACTIVE, FP, SYNC, BP),
  localparam int W     = $clog2(TOTAL)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         step,
  output logic [W-1:0] cnt,
  output logic [1:0]   phase,
  output logic         wrap
);

  if (ACTIVE < 1 || FP < 1 || SYNC < 1 || BP < 1) begin : g_bad_param
    $error("timing_axis: every segment length must be >= 1");
  end

  localparam logic [W-1:0] C_END_ACT  = W'(ACTIVE - 1);
  localparam logic [W-1:0] C_END_FP   = W'(ACTIVE + FP - 1);
  localparam logic [W-1:0] C_END_SYNC = W'(ACTIVE + FP + SYNC - 1);
  localparam logic [W-1:0] C_END_BP   = W'(TOTAL - 1);

  logic [W-1:0] r_cnt;
  phase_t       r_phase;

  assign wrap  = (r_cnt == C_END_BP);
  assign cnt   = r_cnt;
  assign phase = r_phase;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt   <= '0;
      r_phase <= video_timing_pkg::ACT;
    end else if (step) begin
      r_cnt <= wrap ? '0 : r_cnt + 1'b1;
      case (r_phase)
        video_timing_pkg::ACT:  if (r_cnt == C_END_ACT)  r_phase <= video_timing_pkg::FP;
        video_timing_pkg::FP:   if (r_cnt == C_END_FP)   r_phase <= video_timing_pkg::SYNC;
        video_timing_pkg::SYNC: if (r_cnt == C_END_SYNC) r_phase <= video_timing_pkg::BP;
        video_timing_pkg::BP:   if (r_cnt == C_END_BP)   r_phase <= video_timing_pkg::ACT;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/video_timing_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | video_timing_gen: DVI raster timing - syncs, blanking, coordinates, strobes|
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int H_ACTIVE = C_VGA_H_ACTIVE,
  parameter int H_FP     = C_VGA_H_FP,
  parameter int H_SYNC   = C_VGA_H_SYNC,
  parameter int H_BP     = C_VGA_H_BP,
  parameter int V_ACTIVE = C_VGA_V_ACTIVE,
  parameter int V_FP     = C_VGA_V_FP,
  parameter int V_SYNC   = C_VGA_V_SYNC,
  parameter int V_BP     = C_VGA_V_BP,
  parameter bit SYNC_POL = C_VGA_SYNC_POL,
  localparam int H_TOTAL = total_of(H_ACTIVE, H_FP, H_SYNC, H_BP),
  localparam int V_TOTAL = total_of(V_ACTIVE, V_FP, V_SYNC, V_BP),
  localparam int XW      = $clog2(H_TOTAL),
  localparam int YW      = $clog2(V_TOTAL)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  output logic          hsync,
  output logic          vsync,
  output logic          blanking,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic          line_start,
  output logic          frame_start
);

  logic [XW-1:0] w_h_cnt;
  logic [YW-1:0] w_v_cnt;
  logic [1:0]    w_h_phase;
  logic [1:0]    w_v_phase;
  logic          w_h_wrap;
  logic          w_v_wrap_unused;

  timing_axis #(
    .ACTIVE (H_ACTIVE),
    .FP     (H_FP),
    .SYNC   (H_SYNC),
    .BP     (H_BP)
  ) u_h_axis (
    .clk   (clk),
    .rst   (rst),
    .step  (en),
    .cnt   (w_h_cnt),
    .phase (w_h_phase),
    .wrap  (w_h_wrap)
  );

  // The vertical axis moves one line per horizontal wrap.
  timing_axis #(
    .ACTIVE (V_ACTIVE),
    .FP     (V_FP),
    .SYNC   (V_SYNC),
    .BP     (V_BP)
  ) u_v_axis (
    .clk   (clk),
    .rst   (rst),
    .step  (en & w_h_wrap),
    .cnt   (w_v_cnt),
    .phase (w_v_phase),
    .wrap  (w_v_wrap_unused)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hsync       <= ~SYNC_POL;
      vsync       <= ~SYNC_POL;
      blanking    <= 1'b1;
      x           <= '0;
      y           <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else if (en) begin
      hsync       <= (w_h_phase == SYNC) ? SYNC_POL : ~SYNC_POL;
      vsync       <= (w_v_phase == SYNC) ? SYNC_POL : ~SYNC_POL;
      blanking    <= (w_h_phase != ACT) || (w_v_phase != ACT);
      x           <= w_h_cnt;
      y           <= w_v_cnt;
      line_start  <= (w_h_cnt == '0);
      frame_start <= (w_h_cnt == '0) && (w_v_cnt == '0);
    end
  end

endmodule
`default_nettype wire
